// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register (main + skid) with hazard stall and flush.
// Define PIPE_STAGE_PERF_EN to add saturating stall/flush event counters.
module pipe_stage_reg #(
    parameter int              DATA_W           = 32,
    parameter int              ADDR_W           = 32,
    parameter logic [DATA_W-1:0] FLUSH_INSTR    = '0,
    parameter bit              FLUSH_OVER_STALL = 1'b0
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int              CNT_W            = 16
`endif
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] instr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] addr_o
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
`endif
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] skid_instr;
    logic [ADDR_W-1:0] skid_addr;
    logic              flush_eff, in_fire, out_fire;
    logic              load_main_in, load_main_skid, load_skid;

    assign flush_eff = flush_i & (FLUSH_OVER_STALL | ~stall_i);
    // rst_n_i term keeps ready_o low for the whole reset assertion
    assign ready_o   = rst_n_i & (state != FULL) & ~stall_i;
    assign valid_o   = state != EMPTY;
    assign in_fire   = valid_i & ready_o;
    assign out_fire  = valid_o & ready_i & ~stall_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= EMPTY;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush_eff) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    state_nxt    = in_fire ? ONE : EMPTY;
                    load_main_in = in_fire;
                end
                ONE: begin
                    state_nxt    = in_fire ? (out_fire ? ONE : FULL) : (out_fire ? EMPTY : ONE);
                    load_main_in = in_fire & out_fire;
                    load_skid    = in_fire & ~out_fire;
                end
                FULL: begin
                    state_nxt      = out_fire ? ONE : FULL;
                    load_main_skid = out_fire;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            instr_o    <= FLUSH_INSTR;
            addr_o     <= '0;
            skid_instr <= '0;
            skid_addr  <= '0;
        end else if (flush_eff) begin
            instr_o    <= FLUSH_INSTR;
            addr_o     <= '0;
            skid_instr <= '0;
            skid_addr  <= '0;
        end else begin
            if (load_main_in) begin
                instr_o <= instr_i;
                addr_o  <= addr_i;
            end else if (load_main_skid) begin
                instr_o <= skid_instr;
                addr_o  <= skid_addr;
            end
            if (load_skid) begin
                skid_instr <= instr_i;
                skid_addr  <= addr_i;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_i && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (flush_eff && flush_cnt_o != '1) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg; u0 uses stall-over-flush, u1 flush-over-stall.
// Counter checks are compiled in only when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk, rst_n, valid_i, stall_i, flush_i, ready_i;
    logic [31:0] instr_i, addr_i;
    logic        ready0, valid0, ready1, valid1;
    logic [31:0] instr0, addr0, instr1, addr1;
`ifdef PIPE_STAGE_PERF_EN
    logic [3:0]  stall_cnt0, flush_cnt0, stall_cnt1, flush_cnt1;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] q[$];

    pipe_stage_reg #(
        .DATA_W(32), .ADDR_W(32), .FLUSH_INSTR(NOP), .FLUSH_OVER_STALL(1'b0)
`ifdef PIPE_STAGE_PERF_EN
        , .CNT_W(4)
`endif
    ) u0 (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready0),
        .instr_i(instr_i), .addr_i(addr_i), .stall_i(stall_i), .flush_i(flush_i),
        .valid_o(valid0), .ready_i(ready_i), .instr_o(instr0), .addr_o(addr0)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt_o(stall_cnt0), .flush_cnt_o(flush_cnt0)
`endif
    );

    pipe_stage_reg #(
        .DATA_W(32), .ADDR_W(32), .FLUSH_INSTR(NOP), .FLUSH_OVER_STALL(1'b1)
`ifdef PIPE_STAGE_PERF_EN
        , .CNT_W(4)
`endif
    ) u1 (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready1),
        .instr_i(instr_i), .addr_i(addr_i), .stall_i(stall_i), .flush_i(flush_i),
        .valid_o(valid1), .ready_i(ready_i), .instr_o(instr1), .addr_o(addr1)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt_o(stall_cnt1), .flush_cnt_o(flush_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model for u0: a two-deep FIFO of expected beats checked every edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            automatic bit rdy = (q.size() < 2) && !stall_i;
            vectors++;
            if (ready0 !== rdy) begin
                miscompares++;
                $display("FAIL sb_ready: got %b want %b", ready0, rdy);
            end
            vectors++;
            if (valid0 !== (q.size() != 0)) begin
                miscompares++;
                $display("FAIL sb_valid: got %b want %b", valid0, q.size() != 0);
            end
            if (q.size() != 0) begin
                vectors++;
                if ({instr0, addr0} !== q[0]) begin
                    miscompares++;
                    $display("FAIL sb_data: got %h want %h", {instr0, addr0}, q[0]);
                end
            end
            if (flush_i && !stall_i) begin
                q.delete();
            end else begin
                if (q.size() != 0 && ready_i && !stall_i) void'(q.pop_front());
                if (valid_i && rdy) q.push_back({instr_i, addr_i});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] adr);
        valid_i = v;
        instr_i = ins;
        addr_i  = adr;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        stall_i = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b0;
        repeat (2) tick();
        vectors++;
        if ({valid0, ready0, ready1} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_vr: got %b want 000", {valid0, ready0, ready1});
        end
        vectors++;
        if ({instr0, addr0} !== {NOP, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_data: got %h want %h", {instr0, addr0}, {NOP, 32'h0});
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (ready0 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b want 1", ready0);
        end
    endtask

    task automatic test_single();
        ready_i = 1'b1;
        drive(1'b1, 32'hDEAD_BEEF, 32'h4);
        #1;
        vectors++;
        if (ready0 !== 1'b1) begin
            miscompares++;
            $display("FAIL single_ready: got %b want 1", ready0);
        end
        tick();
        drive(1'b0, 32'h0, 32'h0);
        vectors++;
        if ({valid0, instr0, addr0} !== {1'b1, 32'hDEAD_BEEF, 32'h4}) begin
            miscompares++;
            $display("FAIL single_out: got %h want %h", {valid0, instr0, addr0}, {1'b1, 32'hDEAD_BEEF, 32'h4});
        end
        tick();
        vectors++;
        if ({valid0, instr0} !== {1'b0, 32'hDEAD_BEEF}) begin
            miscompares++;
            $display("FAIL single_pop_keep: got %h want %h", {valid0, instr0}, {1'b0, 32'hDEAD_BEEF});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_seq [3] = '{32'hA, 32'hB, 32'hC};
        ready_i = 1'b0;
        drive(1'b1, 32'hA, 32'h100);
        tick();
        drive(1'b1, 32'hB, 32'h104);
        tick();
        drive(1'b1, 32'hC, 32'h108);
        #1;
        vectors++;
        if (ready0 !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_full_ready: got %b want 0", ready0);
        end
        tick();
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({valid0, instr0} !== {1'b1, exp_seq[i]}) begin
                miscompares++;
                $display("FAIL b2b_order%0d: got %h want %h", i, {valid0, instr0}, {1'b1, exp_seq[i]});
            end
            tick();
            if (i == 1) drive(1'b0, 32'h0, 32'h0);
        end
        vectors++;
        if (valid0 !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: got %b want 0", valid0);
        end
    endtask

    task automatic test_stall();
        ready_i = 1'b0;
        drive(1'b1, 32'hA, 32'h200);
        tick();
        drive(1'b1, 32'hD, 32'h204);
        stall_i = 1'b1;
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (ready0 !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_ready%0d: got %b want 0", i, ready0);
            end
            tick();
            vectors++;
            if ({valid0, instr0, addr0} !== {1'b1, 32'hA, 32'h200}) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got %h want %h", i, {valid0, instr0, addr0}, {1'b1, 32'hA, 32'h200});
            end
        end
        stall_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        vectors++;
        if (valid0 !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_release: got %b want 0", valid0);
        end
    endtask

    task automatic test_flush();
        ready_i = 1'b0;
        drive(1'b1, 32'hA, 32'h300);
        tick();
        drive(1'b1, 32'hB, 32'h304);
        tick();
        drive(1'b1, 32'hE, 32'h308);
        flush_i = 1'b1;
        tick();
        vectors++;
        if ({valid0, instr0, addr0} !== {1'b0, NOP, 32'h0}) begin
            miscompares++;
            $display("FAIL flush_full: got %h want %h", {valid0, instr0, addr0}, {1'b0, NOP, 32'h0});
        end
        flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        drive(1'b1, 32'hA, 32'h310);
        tick();
        drive(1'b1, 32'hF, 32'h314);
        flush_i = 1'b1;
        #1;
        vectors++;
        if (ready0 !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_one_ready: got %b want 1", ready0);
        end
        tick();
        flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        vectors++;
        if (valid0 !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_drop: got %b want 0", valid0);
        end
    endtask

    task automatic test_flush_stall();
        ready_i = 1'b0;
        drive(1'b1, 32'hA, 32'h400);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        stall_i = 1'b1;
        flush_i = 1'b1;
        tick();
        vectors++;
        if ({valid0, instr0, addr0} !== {1'b1, 32'hA, 32'h400}) begin
            miscompares++;
            $display("FAIL fs_stall_wins: got %h want %h", {valid0, instr0, addr0}, {1'b1, 32'hA, 32'h400});
        end
        vectors++;
        if ({valid1, instr1, addr1} !== {1'b0, NOP, 32'h0}) begin
            miscompares++;
            $display("FAIL fs_flush_wins: got %h want %h", {valid1, instr1, addr1}, {1'b0, NOP, 32'h0});
        end
        stall_i = 1'b0;
        flush_i = 1'b0;
        drive(1'b1, 32'hB, 32'h404);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        vectors++;
        if (ready0 !== 1'b0) begin
            miscompares++;
            $display("FAIL fs_full_ready: got %b want 0", ready0);
        end
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({valid0, instr0, addr0, valid1} !== {1'b0, NOP, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset: got %h want %h", {valid0, instr0, addr0, valid1}, {1'b0, NOP, 32'h0, 1'b0});
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_perf();
        vectors++;
        if ({stall_cnt0, flush_cnt0} !== 8'h00) begin
            miscompares++;
            $display("FAIL perf_reset: got %h want 00", {stall_cnt0, flush_cnt0});
        end
        stall_i = 1'b1;
        repeat (20) tick();
        stall_i = 1'b0;
        vectors++;
        if ({stall_cnt0, stall_cnt1} !== 8'hFF) begin
            miscompares++;
            $display("FAIL perf_stall_sat: got %h want ff", {stall_cnt0, stall_cnt1});
        end
        for (int i = 0; i < 2; i++) begin
            flush_i = 1'b1;
            tick();
            flush_i = 1'b0;
            tick();
        end
        vectors++;
        if ({flush_cnt0, flush_cnt1, stall_cnt0} !== 12'h22F) begin
            miscompares++;
            $display("FAIL perf_flush: got %h want 22f", {flush_cnt0, flush_cnt1, stall_cnt0});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_flush();
        test_flush_stall();
`ifdef PIPE_STAGE_PERF_EN
        test_perf();
`endif
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end
endmodule
